majority_serial: RTL and testbench

Bit-serial majority voter. It is the receive-side counterpart of the parallel majority block: it accepts an N-bit frame one bit per handshake, accumulates the ones count, and presents the majority decision on a valid/ready output. It sits behind a serialising link where the full vector is never available in parallel.

---
 rtl/maj_pkg.sv | 19 +
 rtl/majority_decide.sv | 18 +
 rtl/majority_serial.sv | 122 ++++++++++++
 tb/tb_majority_serial.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared types and helpers for the majority voters (serial and parallel paths).
package maj_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } maj_state_t;

  // Width needed to hold a ones count of 0..n.
  function automatic int maj_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Exact half: only possible for even n.
  function automatic logic is_tie(input int count, input int n);
    return (count << 1) == n;
  endfunction

endpackage

// File: rtl/majority_decide.sv
// Combinational majority decision from a ones count: y = count > N/2, tie = 2*count == N.
module majority_decide
  import maj_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = maj_cw(N)
) (
  input  logic [CW-1:0] count,
  output logic          y,
  output logic          tie
);

  localparam logic [CW-1:0] HALF = CW'(N >> 1);

  assign y   = count > HALF;
  assign tie = is_tie(int'(count), N);

endmodule

// File: rtl/majority_serial.sv
// Bit-serial majority voter: collects N bits over a valid/ready link, then offers y/tie.
// Optional build macro MAJ_SERIAL_COUNT_EN adds the registered ones count output.
module majority_serial
  import maj_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = maj_cw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  output logic          tie
`ifdef MAJ_SERIAL_COUNT_EN
  ,
  output logic [CW-1:0] ones
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // input side is ready only in COLLECT, the output side valid only in RESULT.
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  maj_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] acc_inc;
  logic          y_q, y_d;
  logic          tie_q, tie_d;
  logic          dec_y, dec_tie;
  logic          accept, last_bit, drop;
`ifdef MAJ_SERIAL_COUNT_EN
  logic [CW-1:0] ones_q, ones_d;
`endif

  assign acc_inc  = acc_q + CW'(in_bit);
  assign accept   = (state_q == COLLECT) && in_valid && !clear;
  assign last_bit = accept && (cnt_q == LAST);
  assign drop     = clear || ((state_q == RESULT) && out_ready);

  majority_decide #(.N(N)) u_decide (
    .count (acc_inc),
    .y     (dec_y),
    .tie   (dec_tie)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_bit) state_d = RESULT;
      RESULT:  if (clear || out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == RESULT);
  end

  // clear wins over a same-cycle input bit, and over a same-cycle result accept.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    y_d   = y_q;
    tie_d = tie_q;
`ifdef MAJ_SERIAL_COUNT_EN
    ones_d = ones_q;
`endif
    if (drop) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = acc_inc;
      if (last_bit) begin
        y_d   = dec_y;
        tie_d = dec_tie;
`ifdef MAJ_SERIAL_COUNT_EN
        ones_d = acc_inc;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      y_q   <= 1'b0;
      tie_q <= 1'b0;
`ifdef MAJ_SERIAL_COUNT_EN
      ones_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      y_q   <= y_d;
      tie_q <= tie_d;
`ifdef MAJ_SERIAL_COUNT_EN
      ones_q <= ones_d;
`endif
    end
  end

  assign y   = y_q;
  assign tie = tie_q;
`ifdef MAJ_SERIAL_COUNT_EN
  assign ones = ones_q;
`endif

endmodule

// File: tb/tb_majority_serial.sv
// Bench for majority_serial: three instances (N=8, N=7, N=1) against a counting model.
module tb_majority_serial;

  logic       clk;
  logic       rst;
  logic [2:0] clear_v, in_valid_v, in_bit_v, out_ready_v;
  logic [2:0] in_ready_v, out_valid_v, y_v, tie_v;
  logic [7:0] ones_v [3];

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];  // {y, tie, ones[7:0]}

`ifdef MAJ_SERIAL_COUNT_EN
  logic [3:0] ones8;
  logic [2:0] ones7;
  logic [0:0] ones1;
  assign ones_v[0] = 8'(ones8);
  assign ones_v[1] = 8'(ones7);
  assign ones_v[2] = 8'(ones1);
`else
  assign ones_v[0] = '0;
  assign ones_v[1] = '0;
  assign ones_v[2] = '0;
`endif

  majority_serial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .in_bit(in_bit_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .y(y_v[0]), .tie(tie_v[0])
`ifdef MAJ_SERIAL_COUNT_EN
    , .ones(ones8)
`endif
  );

  majority_serial #(.N(7)) dut7 (
    .clk(clk), .rst(rst), .clear(clear_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .in_bit(in_bit_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .y(y_v[1]), .tie(tie_v[1])
`ifdef MAJ_SERIAL_COUNT_EN
    , .ones(ones7)
`endif
  );

  majority_serial #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .in_bit(in_bit_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .y(y_v[2]), .tie(tie_v[2])
`ifdef MAJ_SERIAL_COUNT_EN
    , .ones(ones1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int nlen(input int k);
    case (k)
      0: return 8;
      1: return 7;
      default: return 1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // gap < 0 means a random number of idle cycles before each bit.
  task automatic send_bits(input int k, input logic [254:0] bits, input int cnt, input int gap);
    int g;
    for (int i = 0; i < cnt; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        in_valid_v[k] = 1'b0;
        in_bit_v[k]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (out_valid_v[k] !== 1'b0) begin
          errors++;
          $display("FAIL gap_out_valid k=%0d got %b want 0", k, out_valid_v[k]);
        end
      end
      checks++;
      if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL collect_handshake k=%0d bit=%0d out_valid=%b in_ready=%b want 0/1",
                 k, i, out_valid_v[k], in_ready_v[k]);
      end
      in_valid_v[k] = 1'b1;
      in_bit_v[k]   = bits[i];
      @(negedge clk);
    end
    in_valid_v[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [254:0] bits, input int gap);
    int n;
    int cnt1;
    n = nlen(k);
    send_bits(k, bits, n, gap);
    cnt1 = 0;
    for (int i = 0; i < n; i++) cnt1 += int'(bits[i]);
    exp_q.push_back({(2 * cnt1 > n), (2 * cnt1 == n), 8'(cnt1)});
    checks++;
    if (out_valid_v[k] !== 1'b1 || in_ready_v[k] !== 1'b0) begin
      errors++;
      $display("FAIL result_latency k=%0d out_valid=%b in_ready=%b want 1/0",
               k, out_valid_v[k], in_ready_v[k]);
    end
  endtask

  task automatic accept_result(input int k, input int hold);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty k=%0d got 0 entries want >=1", k);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    out_ready_v[k] = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (out_valid_v[k] !== 1'b1 || in_ready_v[k] !== 1'b0 || y_v[k] !== e[9]) begin
        errors++;
        $display("FAIL result_hold k=%0d out_valid=%b in_ready=%b y=%b want 1/0/%b",
                 k, out_valid_v[k], in_ready_v[k], y_v[k], e[9]);
      end
    end
    checks++;
    if (y_v[k] !== e[9] || tie_v[k] !== e[8]) begin
      errors++;
      $display("FAIL result_value k=%0d y=%b tie=%b want %b/%b", k, y_v[k], tie_v[k], e[9], e[8]);
    end
`ifdef MAJ_SERIAL_COUNT_EN
    checks++;
    if (ones_v[k] !== e[7:0]) begin
      errors++;
      $display("FAIL result_ones k=%0d got %0d want %0d", k, ones_v[k], e[7:0]);
    end
`endif
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    checks++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1 || y_v[k] !== e[9]) begin
      errors++;
      $display("FAIL after_accept k=%0d out_valid=%b in_ready=%b y=%b want 0/1/%b",
               k, out_valid_v[k], in_ready_v[k], y_v[k], e[9]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1 || y_v[k] !== 1'b0 ||
          tie_v[k] !== 1'b0 || ones_v[k] !== 8'd0) begin
        errors++;
        $display("FAIL %s k=%0d out_valid=%b in_ready=%b y=%b tie=%b ones=%0d want 0/1/0/0/0",
                 tag, k, out_valid_v[k], in_ready_v[k], y_v[k], tie_v[k], ones_v[k]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    send_frame(0, 255'(8'b0000_1111), 0);
    accept_result(0, 0);
  endtask

  task automatic test_gaps();
    send_frame(0, 255'(8'b0001_1111), 1);
    accept_result(0, 0);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 255'(8'hFF), 0);
    accept_result(0, 5);
    send_frame(0, 255'(8'h00), 0);
    accept_result(0, 0);
  endtask

  task automatic test_clear();
    send_bits(0, 255'(3'b111), 3, 0);
    clear_v[0] = 1'b1; in_valid_v[0] = 1'b1; in_bit_v[0] = 1'b1;
    @(negedge clk);
    clear_v[0] = 1'b0; in_valid_v[0] = 1'b0;
    send_frame(0, 255'(8'b1101_0101), 0);
    accept_result(0, 0);
    // clear while a result is pending, with out_ready also high
    send_frame(0, 255'($urandom_range(0, 255)), 0);
    clear_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    @(negedge clk);
    clear_v[0] = 1'b0; out_ready_v[0] = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_result k=0 out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
    end
    send_frame(0, 255'(8'hFF), 0);
    accept_result(0, 0);
  endtask

  task automatic test_async_reset();
    send_bits(0, 255'(5'b11111), 5, 0);
    #2 rst = 1'b1;
    #1 check_idle_zero("async_reset_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 255'(8'hFF), 0);
    #2 rst = 1'b1;
    #1 check_idle_zero("async_reset_mid_result");
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 255'(8'b1111_0000), 0);
    accept_result(0, 0);
  endtask

  task automatic test_n7();
    send_frame(1, 255'(7'b000_0111), 0);
    accept_result(1, 0);
    send_frame(1, 255'(7'b000_1111), 0);
    accept_result(1, 0);
  endtask

  task automatic test_n1();
    for (int i = 0; i < 6; i++) begin
      send_frame(2, 255'(i % 2), -1);
      accept_result(2, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send_frame(0, 255'($urandom_range(0, 255)), -1);
      accept_result(0, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 10; i++) begin
      send_frame(1, 255'($urandom_range(0, 127)), -1);
      accept_result(1, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_v = '0; in_valid_v = '0; in_bit_v = '0; out_ready_v = '0;
    test_reset();
    test_tie();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_n7();
    test_n1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
